// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: line-source select codes
// driven by the TX control FSM and the parity-type encoding.
package uart_pkg;

   localparam logic [1:0] MUX_STOP  = 2'b00;
   localparam logic [1:0] MUX_START = 2'b01;
   localparam logic [1:0] MUX_SER   = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity generator: captures the parity of a DATA_WIDTH-bit word
// on the load strobe; par_typ selects even (0) or odd (1) parity.
module uart_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   logic par_bit_reg;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_bit_reg <= 1'b0;
      end else if (load) begin
         par_bit_reg <= (^data) ^ par_typ;
      end
   end

   assign par_bit = par_bit_reg;

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmitter data path: byte capture, LSB-first serializer, bit counter
// and registered line mux. Parity generation is present only with UART_TX_PARITY_EN.
module uart_tx_datapath
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  busy,
   input  logic                  PAR_TYP,
   input  logic                  ser_en,
   input  logic [1:0]            mux_sel,
   output logic                  ser_done,
   output logic                  TX_OUT
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg_reg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic [CNT_W-1:0]      bit_cnt_next;
   logic                  tx_out_reg;
   logic                  mux_out;
   logic                  par_bit;
   logic                  load;
   logic                  shift;

   // A new byte is accepted when idle, or during the stop bit for gapless frames.
   assign load  = DATA_VALID && (!busy || (mux_sel == MUX_STOP));
   assign shift = ser_en && (mux_sel == MUX_SER);

   assign ser_done = shift && (bit_cnt_reg == CNT_MAX);

`ifdef UART_TX_PARITY_EN
   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .CLK     (CLK),
      .RST     (RST),
      .load    (load),
      .data    (P_DATA),
      .par_typ (PAR_TYP),
      .par_bit (par_bit)
   );
`else
   logic unused_par_typ;
   assign unused_par_typ = PAR_TYP;
   assign par_bit        = 1'b1;
`endif

   // Load has priority over shift if a misbehaving FSM asserts both.
   always_comb begin
      shreg_next   = shreg_reg;
      bit_cnt_next = bit_cnt_reg;
      if (load) begin
         shreg_next   = P_DATA;
         bit_cnt_next = '0;
      end else begin
         if (shift) begin
            shreg_next = shreg_reg >> 1;
         end
         if (!ser_en) begin
            bit_cnt_next = '0;
         end else if (shift && (bit_cnt_reg != CNT_MAX)) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      mux_out = 1'b1;
      case (mux_sel)
         MUX_START: mux_out = 1'b0;
         MUX_SER:   mux_out = shreg_reg[0];
         MUX_PAR:   mux_out = par_bit;
         default:   mux_out = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_out_reg  <= 1'b1;
      end else begin
         shreg_reg   <= shreg_next;
         bit_cnt_reg <= bit_cnt_next;
         tx_out_reg  <= mux_out;
      end
   end

   assign TX_OUT = tx_out_reg;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath: plays the TX FSM role and compares
// the line against a frame-level model (start, data LSB-first, parity, stop).
module tb_uart_tx_datapath;

   localparam int DW = 8;

   logic          CLK;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          DATA_VALID;
   logic          busy;
   logic          PAR_TYP;
   logic          ser_en;
   logic [1:0]    mux_sel;
   logic          ser_done;
   logic          TX_OUT;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_datapath #(
      .DATA_WIDTH (DW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .busy       (busy),
      .PAR_TYP    (PAR_TYP),
      .ser_en     (ser_en),
      .mux_sel    (mux_sel),
      .ser_done   (ser_done),
      .TX_OUT     (TX_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Parity bit the line should carry in the parity slot.
   function automatic logic exp_par(input logic [DW-1:0] d, input logic t);
`ifdef UART_TX_PARITY_EN
      return logic'($countones(d) % 2) ^ t;
`else
      return 1'b1;
`endif
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] ms, input logic se, input logic bz);
      mux_sel = ms;
      ser_en  = se;
      busy    = bz;
   endtask

   // One frame as the FSM would sequence it. extra_ser holds ser past done;
   // rst_bit >= 0 drops reset after that data bit reaches the line.
   task automatic run_frame(input logic [DW-1:0] data, input logic typ, input bit preloaded,
                            input bit bb_load, input logic [DW-1:0] bb_data, input logic bb_typ,
                            input bit junk_load, input int extra_ser, input int rst_bit);
      logic exp_bit;
      if (!preloaded) begin
         drive(2'b00, 1'b0, 1'b0);
         DATA_VALID = 1'b1; P_DATA = data; PAR_TYP = typ;
         step();
         check("idle_load_tx", TX_OUT, 1);
         DATA_VALID = 1'b0;
      end
      drive(2'b01, 1'($urandom_range(0, 1)), 1'b1);
      P_DATA = DW'($urandom);
      #1 check("start_done", ser_done, 0);
      step();
      check("start_bit", TX_OUT, 0);
      for (int k = 0; k < DW + extra_ser; k++) begin
         drive(2'b10, 1'b1, 1'b1);
         if (junk_load && k == 2) begin
            DATA_VALID = 1'b1; P_DATA = 8'h11; PAR_TYP = ~typ;
         end
         #1 check($sformatf("ser_done_k%0d", k), ser_done, (k >= DW - 1) ? 1 : 0);
         step();
         DATA_VALID = 1'b0;
         exp_bit = (k < DW) ? data[k] : 1'b0;
         check($sformatf("data_bit%0d", k), TX_OUT, exp_bit);
         if (k == rst_bit) begin
            RST = 1'b0;
            #1;
            check("rst_mid_tx", TX_OUT, 1);
            check("rst_mid_done", ser_done, 0);
            drive(2'b00, 1'b0, 1'b0);
            #2 RST = 1'b1;
            return;
         end
      end
      drive(2'b11, 1'b0, 1'b1);
      step();
      check("parity_bit", TX_OUT, exp_par(data, typ));
      drive(2'b00, 1'b0, 1'b1);
      if (bb_load) begin
         DATA_VALID = 1'b1; P_DATA = bb_data; PAR_TYP = bb_typ;
      end
      step();
      check("stop_bit", TX_OUT, 1);
      DATA_VALID = 1'b0;
      busy = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] d, nd;
      logic          t, nt;
      bit            pend, bb;

      RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_TYP = 1'b0;
      drive(2'b00, 1'b0, 1'b0);
      #12;
      check("reset_tx", TX_OUT, 1);
      check("reset_done", ser_done, 0);
      RST = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_tx", TX_OUT, 1);
         check("idle_done", ser_done, 0);
      end

      run_frame(8'hA5, 1'b0, 0, 0, '0, 1'b0, 0, 0, -1);
      run_frame(8'h00, 1'b1, 0, 0, '0, 1'b0, 0, 0, -1);
      run_frame(8'hFF, 1'b1, 0, 1, 8'h3C, 1'b0, 0, 0, -1);
      run_frame(8'h3C, 1'b0, 1, 0, '0, 1'b0, 0, 0, -1);
      run_frame(8'hA5, 1'b0, 0, 0, '0, 1'b0, 1, 0, -1);
      run_frame(8'hC3, 1'b1, 0, 0, '0, 1'b0, 0, 2, -1);
      run_frame(8'hE7, 1'b0, 0, 0, '0, 1'b0, 0, 0, 3);
      check("post_rst_tx", TX_OUT, 1);
      run_frame(8'h5A, 1'b0, 0, 0, '0, 1'b0, 0, 0, -1);

      // Parity slot must read back as 1 when the parity generator is absent.
      drive(2'b11, 1'b0, 1'b0);
      step();
      check("mux_par_idle", TX_OUT, exp_par(8'h5A, 1'b0));
      drive(2'b00, 1'b0, 1'b0);
      step();

      pend = 0; nd = '0; nt = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (pend) begin
            d = nd; t = nt;
         end else begin
            d = DW'($urandom); t = 1'($urandom_range(0, 1));
         end
         bb = ($urandom_range(0, 2) == 0);
         nd = DW'($urandom); nt = 1'($urandom_range(0, 1));
         run_frame(d, t, pend, bb, nd, nt, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, -1);
         pend = bb;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_datapath.md
# uart_tx_datapath

Data path of the UART transmitter, directly downstream of the TX control FSM. It captures the parallel byte and computes parity. It shifts data LSB-first under the FSM's `ser_en`/`mux_sel` control, returns `ser_done`, and drives the registered serial line `TX_OUT`. One bit is sent per `CLK` cycle; `CLK` is the bit clock.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (range 5–9).
- `CLK` in 1: bit clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `P_DATA` in DATA_WIDTH: parallel byte; sampled only on load.
- `DATA_VALID` in 1: upstream strobe that the byte on `P_DATA` is valid.
- `busy` in 1: from FSM; high while a frame is in flight.
- `PAR_TYP` in 1: parity type; 0 = even, 1 = odd. Sampled on load.
- `ser_en` in 1: from FSM; enables the serializer.
- `mux_sel` in 2: from FSM; selects the line source (codes under Operation).
- `ser_done` out 1: combinational; high on the last data-bit cycle.
- `TX_OUT` out 1: registered serial line; idles high.

## Operation
- Line source codes, shared with the FSM:
  - `MUX_STOP` = 2'b00: drive 1. Also used for idle and any unassigned code.
  - `MUX_START` = 2'b01: drive 0.
  - `MUX_SER` = 2'b10: drive `shreg[0]`.
  - `MUX_PAR` = 2'b11: drive the parity bit.
- Load condition: `DATA_VALID && (!busy || mux_sel == MUX_STOP)`. This covers idle accept and back-to-back accept during the stop bit.
- On load:
  - `shreg` ← `P_DATA`.
  - `par_bit` ← `^P_DATA ^ PAR_TYP`.
  - `bit_cnt` ← 0.
- Load while `busy` and not in stop: ignored, no state change.
- Shift condition: `ser_en && mux_sel == MUX_SER`.
  - On shift, `shreg` shifts right with 0 fill, and `bit_cnt` increments.
  - When `ser_en` is high in start, no shift happens.
- `ser_done` = shift condition && `bit_cnt == DATA_WIDTH-1`.
- `bit_cnt` is $clog2(DATA_WIDTH) bits wide and clears to 0 whenever `ser_en` is low. It never wraps past DATA_WIDTH-1 under a compliant FSM.
  - If `ser_en` is held high past done, `bit_cnt` saturates at DATA_WIDTH-1 and `ser_done` stays high.
- Reset mid-frame: `shreg`, `par_bit` and `bit_cnt` clear to 0 immediately, and `TX_OUT` goes to 1. The partial frame is abandoned with no recovery.

## Timing
- Reset values:
  - `TX_OUT` = 1.
  - `ser_done` = 0.
  - `shreg` = 0, `bit_cnt` = 0, `par_bit` = 0.
- `TX_OUT` lags `mux_sel` by exactly one cycle: `TX_OUT` is registered from the mux output.
- Data bit k (k = 0..DATA_WIDTH-1) appears on the mux during the (k+1)-th cycle of `mux_sel == MUX_SER`, and on `TX_OUT` one cycle later.
- `ser_done` is high in the same cycle as data bit DATA_WIDTH-1, so the FSM leaves ser after exactly DATA_WIDTH cycles.
- Frame length on `TX_OUT`: 1 start + DATA_WIDTH data + 1 parity (if PAR_EN) + 1 stop. It contains no gap when the next load happens in stop.
- Load and shift never coincide under a compliant FSM. If both occur, load wins.

## Configuration
- `UART_TX_PARITY_EN` defined: parity generator is present and `MUX_PAR` drives `par_bit`.
- `UART_TX_PARITY_EN` undefined:
  - The parity logic is removed and `PAR_TYP` is ignored.
  - `MUX_PAR` drives 1, identical to a stop bit.
  - The port list is unchanged.

## Structure
- Package `uart_pkg` holds:
  - The `MUX_STOP`/`MUX_START`/`MUX_SER`/`MUX_PAR` localparams.
  - The parity-type constants `PAR_EVEN` = 0 and `PAR_ODD` = 1.
- The FSM imports the same package.
- One sub-module, `uart_parity_calc`: registered parity of `DATA_WIDTH` bits, with load strobe and type input. It is instantiated only under `UART_TX_PARITY_EN`.
- The shift register, counter and output mux live in the top module.

## Test plan
- Reset, idle:
  - Assert `RST` = 0 then release with `mux_sel` = 00 → `TX_OUT` = 1.
  - Hold `mux_sel` = 00 for 20 cycles → no toggle and `ser_done` = 0.
- Basic frame, even parity:
  - Load `P_DATA` = 8'hA5 with `PAR_TYP` = 0 and drive the FSM sequence.
  - → `TX_OUT` = 0, 1,0,1,0,0,1,0,1, then 0 (parity), then 1.
  - → `ser_done` is high only on the 8th ser cycle.
- Odd parity: load 8'h00 with `PAR_TYP` = 1 → parity bit = 1; load 8'hFF → parity bit = 1.
- Back-to-back: assert `DATA_VALID` with 8'h3C during the stop cycle of the previous frame → the next start bit follows the stop bit with no idle cycle, and 8'h3C is sent correctly.
- Ignored load: pulse `DATA_VALID` with 8'h11 during ser of 8'hA5 → 8'hA5 is transmitted intact.
- Reset mid-frame: drop `RST` at data bit 3 → `TX_OUT` = 1 asynchronously; after release, a new frame of 8'h5A is transmitted correctly.
- Build without `UART_TX_PARITY_EN`: `mux_sel` = 11 → `TX_OUT` = 1.
